// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode and funct3 constants shared by the control-transfer decoder
package riscv_pkg;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_BLTU    = 3'b110;
  localparam logic [2:0] F3_BGEU    = 3'b111;
  localparam logic [2:0] F3_JALR    = 3'b000;
endpackage

// File: rtl/br_opcode_decode.sv
// br_opcode_decode: combinational classify of Inst into is_branch/is_jal/is_jalr and the validated hit
module br_opcode_decode
  import riscv_pkg::*;
#(
  parameter bit DETECT_JUMPS = 1'b1
) (
  input  logic [31:0] Inst,
  output logic        is_branch,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        hit
);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       valid_branch;
  logic       valid_jalr;
  logic       unused_bits;
  assign opcode       = Inst[6:0];
  assign funct3       = Inst[14:12];
  assign unused_bits  = ^{Inst[31:15], Inst[11:7]};
  assign is_branch    = opcode == OPC_BRANCH;
  assign is_jal       = opcode == OPC_JAL;
  assign is_jalr      = opcode == OPC_JALR;
  assign valid_branch = is_branch && (funct3 == F3_BEQ || funct3 == F3_BNE || funct3 == F3_BLT ||
                                      funct3 == F3_BGE || funct3 == F3_BLTU || funct3 == F3_BGEU);
  assign valid_jalr   = is_jalr && funct3 == F3_JALR;
  assign hit          = valid_branch | (DETECT_JUMPS & (is_jal | valid_jalr));
endmodule

// File: rtl/branch_dectector.sv
// branch_dectector: registers the control-transfer hit for Inst into Br_Dectected (clk, async rst_n)
module branch_dectector
  import riscv_pkg::*;
#(
  parameter bit DETECT_JUMPS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Inst,
  output logic        Br_Dectected
);
  logic hit;
  logic unused_branch;
  logic unused_jal;
  logic unused_jalr;
  logic br_dectected_d;
  logic br_dectected_q;
  br_opcode_decode #(.DETECT_JUMPS(DETECT_JUMPS)) u_dec (
    .Inst      (Inst),
    .is_branch (unused_branch),
    .is_jal    (unused_jal),
    .is_jalr   (unused_jalr),
    .hit       (hit)
  );
  always_comb br_dectected_d = hit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) br_dectected_q <= 1'b0;
    else        br_dectected_q <= br_dectected_d;
  assign Br_Dectected = br_dectected_q;
endmodule

// File: tb/tb_branch_dectector.sv
// tb_branch_dectector: vector table, corner sequences and randomized model check for branch_dectector
module tb_branch_dectector;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        det1;
  logic        det0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  branch_dectector #(.DETECT_JUMPS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .Inst(inst), .Br_Dectected(det1));
  branch_dectector #(.DETECT_JUMPS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .Inst(inst), .Br_Dectected(det0));

  typedef struct {
    logic [31:0] i;
    logic        e1;
    logic        e0;
  } vec_t;

  function automatic logic ref_hit(input logic [31:0] w, input bit dj);
    int op = int'(w & 32'h7f);
    int f3 = int'((w >> 12) & 32'h7);
    if (op == 'h63) return f3 inside {0, 1, 4, 5, 6, 7};
    if (op == 'h6f) return dj;
    if (op == 'h67) return dj && f3 == 0;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (inst=%08h)", name, act, exp, inst);
    end
  endtask

  task automatic apply(input logic [31:0] w);
    @(negedge clk);
    inst = w;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{32'h00728463, 1'b1, 1'b1},
      '{32'h005282b3, 1'b0, 1'b0},
      '{32'hfe52fee3, 1'b1, 1'b1},
      '{32'h00528333, 1'b0, 1'b0},
      '{32'hff5ff0ef, 1'b1, 1'b0},
      '{32'hf9c382e7, 1'b1, 1'b0},
      '{32'h007302b3, 1'b0, 1'b0},
      '{32'h00002063, 1'b0, 1'b0},
      '{32'h00003063, 1'b0, 1'b0},
      '{32'h000010e7, 1'b0, 1'b0},
      '{32'h00001063, 1'b1, 1'b1},
      '{32'h00004063, 1'b1, 1'b1},
      '{32'h00005063, 1'b1, 1'b1},
      '{32'h00006063, 1'b1, 1'b1},
      '{32'h0000706f, 1'b1, 1'b0},
      '{32'h00002003, 1'b0, 1'b0},
      '{32'h00002023, 1'b0, 1'b0},
      '{32'h000002b7, 1'b0, 1'b0},
      '{32'h00000297, 1'b0, 1'b0},
      '{32'h00000073, 1'b0, 1'b0},
      '{32'h00000061, 1'b0, 1'b0},
      '{32'hfffff0e2, 1'b0, 1'b0},
      '{32'h00728463, 1'b1, 1'b1}
    };

    // reset held low: outputs stay 0 across edges
    inst = 32'h00728463;
    #1;
    chk("reset_async", det1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", det1, 1'b0);
    chk("reset_hold_dj0", det0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_no_early_update", det1, 1'b0);
    @(posedge clk);
    #1;
    chk("release_first_edge", det1, 1'b1);

    foreach (tbl[k]) begin
      apply(tbl[k].i);
      chk($sformatf("tbl%0d_dj1", k), det1, tbl[k].e1);
      chk($sformatf("tbl%0d_dj0", k), det0, tbl[k].e0);
    end

    // held instruction keeps the output for each held cycle
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      chk("hold_beq", det1, 1'b1);
    end

    // mid-operation reset drops the output at once, recovers at the first edge after release
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_drop", det1, 1'b0);
    chk("mid_reset_drop_dj0", det0, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_reset_after_release", det1, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_reset_recover", det1, 1'b1);

    // latency: an Inst change between edges is invisible until the next rising edge
    @(negedge clk);
    inst = 32'h005282b3;
    #2;
    chk("latency_before_edge", det1, 1'b1);
    @(posedge clk);
    #1;
    chk("latency_after_edge", det1, 1'b0);
    @(negedge clk);
    inst = 32'hff5ff0ef;
    #2;
    chk("latency_jal_before", det1, 1'b0);
    @(posedge clk);
    #1;
    chk("latency_jal_after", det1, 1'b1);

    // randomized words biased toward the interesting opcodes
    for (int n = 0; n < 400; n++) begin
      logic [31:0] w;
      logic [6:0]  ops [4];
      ops[0] = 7'h63; ops[1] = 7'h6f; ops[2] = 7'h67; ops[3] = 7'h33;
      w = $urandom;
      if ($urandom_range(3) != 0) w[6:0] = ops[$urandom_range(3)];
      apply(w);
      chk("rand_dj1", det1, ref_hit(w, 1'b1));
      chk("rand_dj0", det0, ref_hit(w, 1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_dectector.md
BRANCH_DECTECTOR -- requirements
Module: branch_dectector

Interface
REQ-001 SHALL have parameter DETECT_JUMPS, default 1; when 1, JAL/JALR count as detected control transfers, when 0 only conditional branches count.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, with all state updating on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset, asynchronous, active-low.
REQ-004 SHALL have port Inst, input, 32 bits; RV32I instruction word currently being examined.
REQ-005 SHALL have port Br_Dectected, output, 1 bit; registered flag that is high when the last sampled Inst was a valid control-transfer instruction.
REQ-006 SHALL use one clock, with an asynchronous active-low reset (rst_n).

Function
REQ-007 SHALL decode opcode = Inst[6:0] and funct3 = Inst[14:12].
REQ-008 SHALL classify opcode 7'b1100011 as a conditional branch, valid only for funct3 in {000,001,100,101,110,111} (BEQ, BNE, BLT, BGE, BLTU, BGEU).
REQ-009 SHALL treat a conditional branch with funct3 010 or 011 as illegal, not detected.
REQ-010 SHALL classify opcode 7'b1101111 as JAL (funct3 ignored).
REQ-011 SHALL classify opcode 7'b1100111 as JALR, valid only for funct3 = 000.
REQ-012 SHALL form combinational hit = valid_branch | (DETECT_JUMPS & (JAL | valid_JALR)).
REQ-013 SHALL deassert hit for every other opcode, including ALU, load/store, LUI/AUIPC, SYSTEM, and any word with Inst[1:0] != 2'b11.
REQ-014 SHALL load Br_Dectected <= hit on every rising clk edge, giving exactly 1 cycle of latency from Inst to output.
REQ-015 SHALL re-evaluate each cycle with no sticky behaviour; if Inst is held for N cycles, the output holds for N cycles.
REQ-016 SHALL keep Br_Dectected glitch-free, driven directly by a flop with no combinational path from Inst to the output.
REQ-017 SHALL ignore all Inst bits other than [14:12] and [6:0] (registers and immediates are don't-care).

Reset
REQ-018 SHALL force Br_Dectected to 0 immediately when rst_n is low, independent of clk.
REQ-019 SHALL hold Br_Dectected at 0 for as long as rst_n is low.
REQ-020 SHALL, on rst_n deassertion, update Br_Dectected first at the next rising clk edge, from the Inst sampled at that edge.
REQ-021 SHALL clear an asserted output to 0 at once on reset mid-operation, with no residual state afterwards.

Structure
REQ-022 SHALL place the opcode constants (OPC_BRANCH 1100011, OPC_JAL 1101111, OPC_JALR 1100111) and the funct3 constants in a shared package, riscv_pkg.
REQ-023 SHALL implement the decode as a combinational sub-module br_opcode_decode (inputs Inst; outputs is_branch, is_jal, is_jalr, hit), with the top module holding only the output flop.
REQ-024 SHALL contain no latches and only one flop of state.

Verification
REQ-025 SHALL verify reset: rst_n=0 with Inst=32'h00728463 -> Br_Dectected=0; after release, at the next posedge -> 1.
REQ-026 SHALL verify the sequence 00728463 (BEQ), 005282b3 (ADD), fe52fee3 (BGEU), 00528333 (ADD), ff5ff0ef (JAL), f9c382e7 (JALR), 007302b3 (ADD) -> outputs 1,0,1,0,1,1,0, each one cycle after sampling.
REQ-027 SHALL verify illegal funct3: Inst=32'h00002063 (branch, funct3 010) -> 0; Inst=32'h000010e7 (JALR, funct3 001) -> 0.
REQ-028 SHALL verify DETECT_JUMPS=0: ff5ff0ef -> 0, f9c382e7 -> 0, 00728463 -> 1.
REQ-029 SHALL verify mid-operation reset: hold BEQ so the output is 1, pulse rst_n low between edges -> output drops to 0 immediately, then returns to 1 at the first posedge after release.
REQ-030 SHALL verify latency: change Inst between edges -> the output changes only at the following rising edge, never combinationally.
